// File: rtl/fm_pkg.sv
// rtl/fm_pkg.sv - shared types and constants for the feature-map writeback unit
package fm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fm_state_t;

  localparam int INT8_MAX  = 127;
  localparam int INT8_MIN  = -128;
  // Accepted beat to wr_en, in cycles.
  localparam int FM_WB_LAT = 3;

endpackage

// File: rtl/fm_requant_lane.sv
// rtl/fm_requant_lane.sv - one lane of bias add, rounding shift, relu and int8 saturation
module fm_requant_lane
  import fm_pkg::*;
#(
  parameter int ACC_WIDTH   = 24,
  parameter int BIAS_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          in_valid,
  input  logic signed [ACC_WIDTH-1:0]   acc,
  input  logic signed [BIAS_WIDTH-1:0]  bias,
  input  logic        [SHIFT_WIDTH-1:0] shift,
  input  logic                          relu_en,
  output logic                          s1_valid,
  output logic                          s2_valid,
  output logic                          out_valid,
  output logic        [DATA_WIDTH-1:0]  out_data
);

  localparam int SUM_W = ACC_WIDTH + 1;
  // Wide enough that the rounding constant for the largest shift never overflows.
  localparam int RND_W = SUM_W + 2**SHIFT_WIDTH;

  localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'(INT8_MAX);
  localparam logic signed [SUM_W-1:0] SAT_LO = SUM_W'(INT8_MIN);

  logic signed [SUM_W-1:0]  s1_sum;
  logic signed [SUM_W-1:0]  s2_res;
  logic signed [RND_W-1:0]  rnd_ext;
  logic signed [RND_W-1:0]  rnd_inc;
  logic signed [RND_W-1:0]  rnd_shr;
  logic        [DATA_WIDTH-1:0] sat;

  // Round half up: add half an LSB of the result before the arithmetic shift.
  always_comb begin
    rnd_ext = RND_W'(s1_sum);
    rnd_inc = '0;
    if (shift != '0) begin
      rnd_inc = RND_W'(1) << (shift - SHIFT_WIDTH'(1));
    end
    rnd_shr = (rnd_ext + rnd_inc) >>> shift;
  end

  // ReLU first, then clamp to the int8 range.
  always_comb begin
    sat = s2_res[DATA_WIDTH-1:0];
    if (relu_en && s2_res[SUM_W-1]) begin
      sat = '0;
    end else if (s2_res > SAT_HI) begin
      sat = DATA_WIDTH'(INT8_MAX);
    end else if (s2_res < SAT_LO) begin
      sat = DATA_WIDTH'(INT8_MIN);
    end
  end

  // Three-stage datapath; the output register only moves on a valid beat.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid  <= 1'b0;
      s1_sum    <= '0;
      s2_valid  <= 1'b0;
      s2_res    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sum <= SUM_W'(acc) + SUM_W'(bias);
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_res <= SUM_W'(rnd_shr);
      end
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_data <= sat;
      end
    end
  end

endmodule

// File: rtl/fm_writeback_unit.sv
// rtl/fm_writeback_unit.sv - per-layer feature-map write controller with requantizing lanes
module fm_writeback_unit
  import fm_pkg::*;
#(
  parameter int CONV_OUT_NUM = 18,
  parameter int DATA_WIDTH   = 8,
  parameter int ACC_WIDTH    = 24,
  parameter int BIAS_WIDTH   = 16,
  parameter int FM_MEM_DEPTH = 13,
  parameter int SHIFT_WIDTH  = 5
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               start,
  input  logic [FM_MEM_DEPTH-1:0]            cfg_base_addr,
  input  logic [FM_MEM_DEPTH:0]              cfg_len,
  input  logic [SHIFT_WIDTH-1:0]             cfg_shift,
  input  logic                               cfg_relu_en,
  input  logic [CONV_OUT_NUM*BIAS_WIDTH-1:0] bias,
  input  logic                               acc_valid,
  output logic                               acc_ready,
  input  logic [CONV_OUT_NUM*ACC_WIDTH-1:0]  acc_data,
  output logic [CONV_OUT_NUM*DATA_WIDTH-1:0] wr_data,
  output logic [FM_MEM_DEPTH-1:0]            wr_addr,
  output logic                               wr_en,
  output logic                               busy,
  output logic                               done
);

  fm_state_t state;
  fm_state_t state_nx;

  logic [FM_MEM_DEPTH:0]   len_q;
  logic [FM_MEM_DEPTH:0]   acc_cnt;
  logic [SHIFT_WIDTH-1:0]  shift_q;
  logic                    relu_q;
  logic [FM_MEM_DEPTH-1:0] wr_ptr;

  logic load_cfg;
  logic accept;

  logic [CONV_OUT_NUM-1:0] lane_s1v;
  logic [CONV_OUT_NUM-1:0] lane_s2v;
  logic [CONV_OUT_NUM-1:0] lane_ov;

  logic pipe_busy;
  logic wr_step;

  // All lanes move in lockstep; reducing over them keeps every valid bit in use.
  assign pipe_busy = (|lane_s1v) | (|lane_s2v);
  assign wr_step   = |lane_s2v;
  assign wr_en     = |lane_ov;

  genvar g;
  generate
    for (g = 0; g < CONV_OUT_NUM; g++) begin : g_lane
      fm_requant_lane #(
        .ACC_WIDTH   (ACC_WIDTH),
        .BIAS_WIDTH  (BIAS_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .SHIFT_WIDTH (SHIFT_WIDTH)
      ) u_lane (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (accept),
        .acc       (acc_data[g*ACC_WIDTH +: ACC_WIDTH]),
        .bias      (bias[g*BIAS_WIDTH +: BIAS_WIDTH]),
        .shift     (shift_q),
        .relu_en   (relu_q),
        .s1_valid  (lane_s1v[g]),
        .s2_valid  (lane_s2v[g]),
        .out_valid (lane_ov[g]),
        .out_data  (wr_data[g*DATA_WIDTH +: DATA_WIDTH])
      );
    end
  endgenerate

  // Layer FSM: next state and handshake outputs.
  always_comb begin
    state_nx  = state;
    acc_ready = 1'b0;
    accept    = 1'b0;
    load_cfg  = 1'b0;
    done      = 1'b0;
    busy      = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (start) begin
          load_cfg = 1'b1;
          state_nx = (cfg_len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        acc_ready = (acc_cnt < len_q);
        accept    = acc_valid && acc_ready;
        if (accept && ((acc_cnt + (FM_MEM_DEPTH+1)'(1)) == len_q)) begin
          state_nx = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The final write stage needs no wait: done lands the cycle after it.
        if (!pipe_busy) begin
          state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Layer config capture and accepted-beat counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      len_q   <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
      acc_cnt <= '0;
    end else if (load_cfg) begin
      len_q   <= cfg_len;
      shift_q <= cfg_shift;
      relu_q  <= cfg_relu_en;
      acc_cnt <= '0;
    end else if (accept) begin
      acc_cnt <= acc_cnt + (FM_MEM_DEPTH+1)'(1);
    end
  end

  // Write address loads alongside the lane output stage; the pointer wraps silently.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr  <= '0;
      wr_addr <= '0;
    end else if (load_cfg) begin
      wr_ptr <= cfg_base_addr;
    end else if (wr_step) begin
      wr_addr <= wr_ptr;
      wr_ptr  <= wr_ptr + FM_MEM_DEPTH'(1);
    end
  end

endmodule
